// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: fetch state encoding,
// datapath widths and the default halt word.
package inst_fetch_pkg;

   localparam int XLEN       = 32;
   localparam int INST_BYTES = 4;

   localparam logic [XLEN-1:0] DEFAULT_HALT_INST = 32'h0000_0000;

   typedef enum logic {
      FETCH  = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

   // Instruction addresses are word aligned; low bits of a target are dropped.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small circular FIFO holding {pc, instruction} pairs between fetch and decode.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fetch_buffer #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head_data = mem[rd_ptr[AW-1:0]];

   // Flush outranks any same-cycle push or pop.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // When full, the write slot is the head slot; a simultaneous pop has already
   // consumed the old head through head_data before this edge overwrites it.
   always_ff @(posedge clk) begin
      if (push && !reset && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: PC, FETCH/HALTED state machine, halt detection and
// redirect handling around fetch_buffer. INST_FETCH_PERF_CNT_EN adds perf counters.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2,
   parameter logic [31:0] HALT_INST = DEFAULT_HALT_INST
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] op_inst_addr,
   input  logic        ip_inst_valid,
   input  logic [31:0] ip_inst_from_imem,
   input  logic        ip_redirect,
   input  logic [31:0] ip_redirect_pc,
   input  logic        ip_stall,
   output logic        op_inst_valid,
   output logic [31:0] op_inst,
   output logic [31:0] op_inst_pc,
   output logic        op_halted
`ifdef INST_FETCH_PERF_CNT_EN
   ,
   output logic [31:0] op_fetch_count,
   output logic [31:0] op_bubble_count
`endif
);

   // Handshake: an entry moves to decode on every cycle where op_inst_valid is 1
   // and ip_stall is 0; a redirect in that cycle cancels the transfer.

   fetch_state_t      state;
   logic [XLEN-1:0]   pc;
   logic              push;
   logic              pop;
   logic              buf_empty;
   logic              buf_full;
   logic [2*XLEN-1:0] head_data;

   assign op_inst_addr  = pc;
   assign op_inst_valid = !buf_empty;
   assign op_inst       = buf_empty ? '0 : head_data[XLEN-1:0];
   assign op_inst_pc    = buf_empty ? '0 : head_data[2*XLEN-1:XLEN];
   assign op_halted     = (state == HALTED) && buf_empty;

   assign pop  = op_inst_valid && !ip_stall;
   assign push = (state == FETCH) && ip_inst_valid && (!buf_full || pop);

   fetch_buffer #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (2 * XLEN)
   ) u_buf (
      .clk       (clk),
      .reset     (reset),
      .flush     (ip_redirect),
      .push      (push),
      .push_data ({pc, ip_inst_from_imem}),
      .pop       (pop),
      .head_data (head_data),
      .empty     (buf_empty),
      .full      (buf_full)
   );

   // The halt word is still enqueued, but the PC stays on its address.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
         pc    <= RESET_PC;
      end else if (ip_redirect) begin
         state <= FETCH;
         pc    <= align_pc(ip_redirect_pc);
      end else if (push) begin
         if (ip_inst_from_imem == HALT_INST) state <= HALTED;
         else                                pc    <= pc + 32'(INST_BYTES);
      end
   end

`ifdef INST_FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         op_fetch_count  <= '0;
         op_bubble_count <= '0;
      end else begin
         if (push) op_fetch_count <= op_fetch_count + 32'd1;
         if ((state == FETCH) && !op_inst_valid) op_bubble_count <= op_bubble_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: expected {pc, inst} pairs are queued by the
// stimulus and a negedge monitor compares every transfer to decode against them.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] op_inst_addr;
  logic        ip_inst_valid;
  logic [31:0] ip_inst_from_imem;
  logic        ip_redirect;
  logic [31:0] ip_redirect_pc;
  logic        ip_stall;
  logic        op_inst_valid;
  logic [31:0] op_inst;
  logic [31:0] op_inst_pc;
  logic        op_halted;
`ifdef INST_FETCH_PERF_CNT_EN
  logic [31:0] op_fetch_count;
  logic [31:0] op_bubble_count;
`endif

  logic [31:0] halt_addr;
  logic [63:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;

  inst_fetch #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2),
    .HALT_INST (32'h0000_0000)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .op_inst_addr      (op_inst_addr),
    .ip_inst_valid     (ip_inst_valid),
    .ip_inst_from_imem (ip_inst_from_imem),
    .ip_redirect       (ip_redirect),
    .ip_redirect_pc    (ip_redirect_pc),
    .ip_stall          (ip_stall),
    .op_inst_valid     (op_inst_valid),
    .op_inst           (op_inst),
    .op_inst_pc        (op_inst_pc),
    .op_halted         (op_halted)
`ifdef INST_FETCH_PERF_CNT_EN
    ,
    .op_fetch_count    (op_fetch_count),
    .op_bubble_count   (op_bubble_count)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;

  // imem model: each word is tagged with its address, except one halt location
  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    return (addr == halt_addr) ? 32'h0000_0000 : (32'hC000_0000 | addr);
  endfunction

  always_comb ip_inst_from_imem = imem_word(op_inst_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input logic [31:0] pc);
    exp_q.push_back({pc, imem_word(pc)});
  endtask

  task automatic do_reset();
    chk("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    reset         = 1'b1;
    ip_inst_valid = 1'b0;
    ip_stall      = 1'b0;
    ip_redirect   = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && op_inst_valid && !ip_stall && !ip_redirect) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop_pc", 64'(op_inst_pc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("pop_pc", 64'(op_inst_pc), 64'(e[63:32]));
        chk("pop_inst", 64'(op_inst), 64'(e[31:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    halt_addr      = 32'hFFFF_FFF0;
    reset          = 1'b1;
    ip_inst_valid  = 1'b0;
    ip_redirect    = 1'b0;
    ip_redirect_pc = 32'h0;
    ip_stall       = 1'b0;

    // reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_valid", 64'(op_inst_valid), 64'd0);
    chk("rst_addr", 64'(op_inst_addr), 64'd0);
    chk("rst_halted", 64'(op_halted), 64'd0);
    chk("rst_inst", 64'(op_inst), 64'd0);
    chk("rst_pc", 64'(op_inst_pc), 64'd0);

    // straight-line fetch
    do_reset();
    ip_inst_valid = 1'b1;
    for (int i = 0; i < 4; i++) expect_fetch(32'(4 * i));
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) ip_inst_valid = 1'b0;
      @(negedge clk);
      chk("line_valid", 64'(op_inst_valid), 64'd1);
      chk("line_addr", 64'(op_inst_addr), 64'(4 * (i + 1)));
    end
    tick();
    @(negedge clk);
    chk("line_empty", 64'(op_inst_valid), 64'd0);
    chk("line_addr_end", 64'(op_inst_addr), 64'h10);
`ifdef INST_FETCH_PERF_CNT_EN
    chk("perf_fetch", 64'(op_fetch_count), 64'd4);
    chk("perf_bubble", 64'(op_bubble_count), 64'd1);
`endif

    // stall / backpressure
    do_reset();
    ip_inst_valid = 1'b1;
    ip_stall      = 1'b1;
    for (int i = 0; i < 4; i++) expect_fetch(32'(4 * i));
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("stall_addr", 64'(op_inst_addr), (i == 0) ? 64'h4 : 64'h8);
      chk("stall_head", 64'(op_inst_pc), 64'h0);
    end
    tick();
    ip_stall = 1'b0;
    tick(); tick();
    ip_inst_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("stall_drained", 64'(op_inst_valid), 64'd0);
    chk("stall_addr_end", 64'(op_inst_addr), 64'h10);

    // imem not ready
    do_reset();
    ip_inst_valid = 1'b1;
    for (int i = 0; i < 3; i++) expect_fetch(32'(4 * i));
    tick();
    ip_inst_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("nrdy_addr", 64'(op_inst_addr), 64'h4);
      chk("nrdy_valid", 64'(op_inst_valid), 64'd0);
    end
    ip_inst_valid = 1'b1;
    tick(); tick();
    ip_inst_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("nrdy_addr_end", 64'(op_inst_addr), 64'hC);

    // redirect with full buffer (entries 0x0 and 0x4 are flushed, never expected)
    do_reset();
    ip_inst_valid = 1'b1;
    ip_stall      = 1'b1;
    tick(); tick();
    ip_redirect    = 1'b1;
    ip_redirect_pc = 32'h0000_0023;
    @(negedge clk);
    chk("redir_full_addr", 64'(op_inst_addr), 64'h8);
    chk("redir_full_head", 64'(op_inst_pc), 64'h0);
    tick();
    ip_redirect = 1'b0;
    ip_stall    = 1'b0;
    expect_fetch(32'h20);
    expect_fetch(32'h24);
    @(negedge clk);
    chk("redir_flushed", 64'(op_inst_valid), 64'd0);
    chk("redir_pc", 64'(op_inst_addr), 64'h20);
    tick();
    @(negedge clk);
    chk("redir_first_valid", 64'(op_inst_valid), 64'd1);
    chk("redir_first_pc", 64'(op_inst_pc), 64'h20);
    tick();
    ip_inst_valid = 1'b0;
    tick(); tick();

    // halt, then redirect out of HALTED
    do_reset();
    halt_addr     = 32'hC;
    ip_inst_valid = 1'b1;
    for (int i = 0; i < 4; i++) expect_fetch(32'(4 * i));
    repeat (4) tick();
    @(negedge clk);
    chk("halt_pending", 64'(op_halted), 64'd0);
    chk("halt_addr_hold", 64'(op_inst_addr), 64'hC);
    tick();
    @(negedge clk);
    chk("halt_set", 64'(op_halted), 64'd1);
    chk("halt_empty", 64'(op_inst_valid), 64'd0);
    tick();
    @(negedge clk);
    chk("halt_stays", 64'(op_halted), 64'd1);
    chk("halt_addr_still", 64'(op_inst_addr), 64'hC);
    ip_redirect    = 1'b1;
    ip_redirect_pc = 32'h4;
    tick();
    ip_redirect = 1'b0;
    expect_fetch(32'h4);
    expect_fetch(32'h8);
    @(negedge clk);
    chk("unhalt", 64'(op_halted), 64'd0);
    chk("unhalt_addr", 64'(op_inst_addr), 64'h4);
    tick(); tick();
    ip_inst_valid = 1'b0;
    tick(); tick();
    halt_addr = 32'hFFFF_FFF0;

    // PC wrap past the top of the address space, unaligned target
    do_reset();
    ip_redirect    = 1'b1;
    ip_redirect_pc = 32'hFFFF_FFFE;
    tick();
    ip_redirect   = 1'b0;
    ip_inst_valid = 1'b1;
    expect_fetch(32'hFFFF_FFFC);
    expect_fetch(32'h0);
    @(negedge clk);
    chk("wrap_aligned", 64'(op_inst_addr), 64'hFFFF_FFFC);
    tick();
    @(negedge clk);
    chk("wrap_addr", 64'(op_inst_addr), 64'h0);
    tick();
    ip_inst_valid = 1'b0;
    tick(); tick();

    // reset mid-run with two buffered entries
    do_reset();
    ip_inst_valid = 1'b1;
    ip_stall      = 1'b1;
    tick(); tick();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_full_addr", 64'(op_inst_addr), 64'h8);
    tick();
    reset         = 1'b0;
    ip_inst_valid = 1'b0;
    ip_stall      = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(op_inst_valid), 64'd0);
    chk("mid_rst_addr", 64'(op_inst_addr), 64'h0);
    chk("mid_rst_halted", 64'(op_halted), 64'd0);
`ifdef INST_FETCH_PERF_CNT_EN
    chk("mid_rst_fetch_cnt", 64'(op_fetch_count), 64'd0);
    chk("mid_rst_bubble_cnt", 64'(op_bubble_count), 64'd0);
`endif
    ip_inst_valid = 1'b1;
    expect_fetch(32'h0);
    tick();
    ip_inst_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("mid_rst_drained", 64'(op_inst_valid), 64'd0);

    chk("final_drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
